// File: rtl/mult_ctrl.sv
// ============================================================================
// Module   : mult_ctrl
// Brief    : Sequencing controller for a shift-add multiplier datapath.
//            Optional abort input enabled by defining MULT_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STRT,
    input  logic                     q0,
`ifdef MULT_CTRL_ABORT_EN
    input  logic                     ABORT,
`endif
    output logic                     ld1,
    output logic                     ld2,
    output logic                     add_en,
    output logic                     shft_con,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [$clog2(WIDTH)-1:0] CNT
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            w_abort;

`ifdef MULT_CTRL_ABORT_EN
    assign w_abort = ABORT;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (STRT) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == C_LAST) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = S_ADD;
                end
            end
            S_FIN: begin
                // DONE is a level: held until the issuer drops STRT
                if (!STRT) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decoded from the state register so reset clears every output at once
    always_comb begin
        ld1      = 1'b0;
        ld2      = 1'b0;
        add_en   = 1'b0;
        shft_con = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld1  = 1'b1;
                ld2  = 1'b1;
                BUSY = 1'b1;
            end
            S_ADD: begin
                add_en = q0;
                BUSY   = 1'b1;
            end
            S_SHIFT: begin
                shft_con = 1'b1;
                BUSY     = 1'b1;
            end
            S_FIN: begin
                DONE = 1'b1;
                BUSY = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_ctrl.sv
// ============================================================================
// Module   : tb_mult_ctrl
// Brief    : Directed scoreboard bench for mult_ctrl (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    typedef struct packed {
        logic strt;
        logic q0;
        logic abort;
    } stim_t;

    typedef struct packed {
        logic          ld1;
        logic          ld2;
        logic          add_en;
        logic          shft;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } obs_t;

    logic          CLK;
    logic          RST;
    logic          STRT;
    logic          q0;
    logic          ld1;
    logic          ld2;
    logic          add_en;
    logic          shft_con;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] CNT;
`ifdef MULT_CTRL_ABORT_EN
    logic          ABORT;
`endif

    stim_t   sq[$];
    obs_t    eq[$];
    string   tq[$];
    int      checks;
    int      errors;
    int      exp_cnt;

    mult_ctrl #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .STRT     (STRT),
        .q0       (q0),
`ifdef MULT_CTRL_ABORT_EN
        .ABORT    (ABORT),
`endif
        .ld1      (ld1),
        .ld2      (ld2),
        .add_en   (add_en),
        .shft_con (shft_con),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .CNT      (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic ld, input logic ad, input logic sh,
                                input logic bz, input logic dn, input int c);
        obs_t o;
        o.ld1    = ld;
        o.ld2    = ld;
        o.add_en = ad;
        o.shft   = sh;
        o.busy   = bz;
        o.done   = dn;
        o.cnt    = CW'(c);
        return o;
    endfunction

    function automatic void push(input logic s, input logic q, input logic a,
                                 input obs_t e, input string tag);
        stim_t st;
        st.strt  = s;
        st.q0    = q;
        st.abort = a;
        sq.push_back(st);
        eq.push_back(e);
        tq.push_back(tag);
    endfunction

    // One full operation as seen from the issuer; mode 0 = STRT pulse,
    // 1 = STRT held through completion, 2 = STRT toggled every cycle.
    function automatic void op(input logic [W-1:0] qb, input int mode, input string nm);
        int k;
        push(1'b1, 1'($urandom), 1'b0, mk(0, 0, 0, 0, 0, exp_cnt), {nm, "_idle"});
        k = 0;
        push((mode == 1) ? 1'b1 : ((mode == 2) ? 1'(k) : 1'b0), 1'($urandom), 1'b0,
             mk(1, 0, 0, 1, 0, exp_cnt), {nm, "_load"});
        for (int i = 0; i < W; i++) begin
            k++;
            push((mode == 1) ? 1'b1 : ((mode == 2) ? 1'(k) : 1'b0), qb[i], 1'b0,
                 mk(0, qb[i], 0, 1, 0, i), $sformatf("%s_add%0d", nm, i));
            k++;
            push((mode == 1) ? 1'b1 : ((mode == 2) ? 1'(k) : 1'b0), 1'($urandom), 1'b0,
                 mk(0, 0, 1, 1, 0, i), $sformatf("%s_shift%0d", nm, i));
        end
        push((mode == 1) ? 1'b1 : 1'b0, 1'($urandom), 1'b0,
             mk(0, 0, 0, 1, 1, W - 1), {nm, "_fin"});
        exp_cnt = W - 1;
    endfunction

    function automatic void trunc(input int n);
        while (sq.size() > n) begin
            void'(sq.pop_back());
            void'(eq.pop_back());
            void'(tq.pop_back());
        end
    endfunction

    task automatic chk(input string tag, input obs_t e);
        obs_t o;
        o = {ld1, ld2, add_en, shft_con, BUSY, DONE, CNT};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic run();
        stim_t s;
        obs_t  e;
        string t;
        while (sq.size() > 0) begin
            @(negedge CLK);
            s     = sq.pop_front();
            STRT  = s.strt;
            q0    = s.q0;
`ifdef MULT_CTRL_ABORT_EN
            ABORT = s.abort;
`endif
            #1;
            e = eq.pop_front();
            t = tq.pop_front();
            chk(t, e);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 0;
        RST     = 1'b1;
        STRT    = 1'b1;
        q0      = 1'b1;
`ifdef MULT_CTRL_ABORT_EN
        ABORT   = 1'b0;
`endif

        // Reset held with STRT high: nothing may launch
        #3;
        chk("rst_hold0", mk(0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold1", mk(0, 0, 0, 0, 0, 0));
        RST = 1'b0;

        // Operation with q0 = 1,0,1,1 in successive ADD cycles
        op(4'b1101, 0, "op1");
        push(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, W - 1), "op1_after");
        run();

        // STRT held across completion: DONE stays, no relaunch
        op(4'b0110, 1, "hold");
        push(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, W - 1), "hold_fin1");
        push(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, W - 1), "hold_fin2");
        push(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 1, 1, W - 1), "hold_release");
        op(4'b1111, 0, "relaunch");
        run();

        // Asynchronous reset in the SHIFT cycle with CNT=2
        op(4'b1010, 0, "rstmid");
        trunc(8);
        run();
        RST = 1'b1;
        #1;
        chk("rst_async", mk(0, 0, 0, 0, 0, 0));
        STRT = 1'b0;
        @(posedge CLK);
        #1;
        RST     = 1'b0;
        exp_cnt = 0;
        op(4'b0011, 0, "post_rst");
        run();

        // STRT toggled while busy
        op(4'b1001, 2, "toggle");
        push(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, W - 1), "toggle_after");
        run();

`ifdef MULT_CTRL_ABORT_EN
        // Abort during the third ADD cycle
        op(4'b0101, 0, "abort");
        trunc(7);
        begin
            stim_t s;
            s       = sq[6];
            s.abort = 1'b1;
            sq[6]   = s;
        end
        push(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), "abort_idle0");
        push(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0), "abort_idle1");
        push(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0), "abort_in_idle");
        exp_cnt = 0;
        run();
        op(4'b1110, 0, "post_abort");
        run();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
